spi_master_fifo: RTL

- Parametrised SPI master: next generation of the LCD byte sender used by the ST7789 display path.
- Adds a TX FIFO, a runtime clock divider, all four CPOL/CPHA modes, configurable frame width and a chip select.
- Carries the D/C bit per word, so the display controller and future SPI peripherals on the data bus can stream words back-to-back without polling busy per byte.

---
 rtl/spi_master_fifo_if.sv | 15 +
 rtl/spi_master_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo_if.sv
// spi_master_fifo_if
//   Push handshake between a word producer and the SPI master TX FIFO.
//   valid_i : producer offers data_i this cycle
//   ready_o : FIFO has room; the word is taken when valid_i && ready_o
//   data_i  : {dc, payload}, DATA_WIDTH+1 bits
interface spi_master_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH:0]   data_i;

  modport master (output valid_i, output data_i, input ready_o);
  modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/spi_master_fifo.sv
// spi_master_fifo
//   SPI master with TX FIFO, runtime divider, CPOL/CPHA modes, chip select
//   and a per-word D/C flag. Frames are DATA_WIDTH bits, MSB first.
//   Optional receive path enabled by defining SPI_RX_EN.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   push_if (slave)   : valid_i / ready_o / data_i {dc, payload}
//   div_i             : half-period length minus 1, in clk_i cycles
//   cpol_i, cpha_i    : SPI mode, latched per frame at LOAD
//   level_o, busy_o   : FIFO occupancy, engine or FIFO active
//   sda_o, scl_o      : MOSI and serial clock
//   dc_o, cs_n_o      : data/command flag of current frame, chip select
//   miso_i            : serial input (SPI_RX_EN only)
//   rx_data_o         : last received frame
//   rx_valid_o        : one-cycle pulse per completed received frame
//
// state | meaning
// IDLE  | cs_n high, scl at last latched cpol, waiting for a FIFO word
// LOAD  | pop head, latch payload/dc/mode/divider, cs_n low
// LEAD  | leading half of a bit, scl = !cpol
// TRAIL | trailing half of a bit, scl = cpol; picks next bit/frame
module spi_master_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  spi_master_fifo_if.slave              push_if,
  input  logic [DIV_WIDTH-1:0]          div_i,
  input  logic                          cpol_i,
  input  logic                          cpha_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          sda_o,
  output logic                          scl_o,
  output logic                          dc_o,
  output logic                          cs_n_o,
  input  logic                          miso_i,
  output logic [DATA_WIDTH-1:0]         rx_data_o,
  output logic                          rx_valid_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, LEAD, TRAIL} state_t;
  state_t r_state, w_state_next;

  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_level;
  logic [DATA_WIDTH:0]   w_head;
  logic                  w_push, w_pop, w_tc, w_last_bit;
  logic [DATA_WIDTH-1:0] r_shift, w_shl;
  logic [BW-1:0]         r_bits;
  logic [DIV_WIDTH-1:0]  r_div, r_cnt;
  logic                  r_cpol, r_cpha, r_sda, r_dc;
  logic                  w_scl, w_cs_n;

  assign push_if.ready_o = (r_level != (AW+1)'(FIFO_DEPTH));
  assign w_push     = push_if.valid_i && push_if.ready_o;
  // LOAD always lasts one cycle, so heading into it means popping now
  assign w_pop      = (w_state_next == LOAD);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_tc       = (r_cnt == '0);
  assign w_last_bit = (r_bits == BW'(1));
  assign w_shl      = r_shift << 1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_if.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (r_level != '0) w_state_next = LOAD;
      LOAD:  w_state_next = LEAD;
      LEAD:  if (w_tc) w_state_next = TRAIL;
      TRAIL: if (w_tc) begin
        if (!w_last_bit)          w_state_next = LEAD;
        else if (r_level != '0)   w_state_next = LOAD;
        else                      w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_scl  = r_cpol;
    w_cs_n = 1'b0;
    case (r_state)
      IDLE:    w_cs_n = 1'b1;
      LEAD:    w_scl  = ~r_cpol;
      default: ;
    endcase
  end

  // Half-period timer reloads on entry to LEAD/TRAIL; r_sda changes only on
  // state entry so it is stable across each sample edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shift <= '0;
      r_bits  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_cpol  <= 1'b1;
      r_cpha  <= 1'b0;
      r_sda   <= 1'b0;
      r_dc    <= 1'b0;
    end else begin
      if (r_state == LOAD) begin
        r_cnt <= r_div;
        if (r_cpha) begin
          r_sda   <= r_shift[DATA_WIDTH-1];
          r_shift <= w_shl;
        end
      end else if (r_state == LEAD || r_state == TRAIL) begin
        r_cnt <= w_tc ? r_div : r_cnt - DIV_WIDTH'(1);
      end
      if (r_state == LEAD && w_tc && !r_cpha && !w_last_bit) begin
        r_shift <= w_shl;
        r_sda   <= w_shl[DATA_WIDTH-1];
      end
      if (r_state == TRAIL && w_tc && !w_last_bit && r_cpha) begin
        r_sda   <= r_shift[DATA_WIDTH-1];
        r_shift <= w_shl;
      end
      if (r_state == TRAIL && w_tc) r_bits <= r_bits - BW'(1);
      if (w_pop) begin
        r_shift <= w_head[DATA_WIDTH-1:0];
        r_dc    <= w_head[DATA_WIDTH];
        r_cpol  <= cpol_i;
        r_cpha  <= cpha_i;
        r_div   <= div_i;
        r_bits  <= BW'(DATA_WIDTH);
        if (!cpha_i) r_sda <= w_head[DATA_WIDTH-1];
      end
    end
  end

  assign level_o = r_level;
  assign busy_o  = (r_state != IDLE) || (r_level != '0);
  assign sda_o   = r_sda;
  assign scl_o   = w_scl;
  assign dc_o    = r_dc;
  assign cs_n_o  = w_cs_n;

`ifdef SPI_RX_EN
  logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data;
  logic                  r_rx_valid;
  logic                  w_sample;

  // Both phases sample at the end of LEAD: for cpha=0 that is the last LEAD
  // cycle, for cpha=1 it is the edge entering TRAIL.
  assign w_sample = (r_state == LEAD) && w_tc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_sample) r_rx_shift <= (r_rx_shift << 1) | DATA_WIDTH'(miso_i);
      if (r_state == TRAIL && w_tc && w_last_bit) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
`else
  logic w_unused_miso;
  assign w_unused_miso = miso_i;
  assign rx_data_o     = '0;
  assign rx_valid_o    = 1'b0;
`endif
endmodule
